// File: rtl/pwm_mux_arbiter.sv
// pwm_mux_arbiter: shares one 8:1 PWM compare-value mux among eight
// requesters. The arbiter drives the mux select and captures the selected
// value. It then forwards the value, tagged with its channel index, to a single
// downstream writer over a valid/ready handshake.
// Build option: define PWMMUX_FIXED_PRIO_EN for lowest-index-wins arbitration.
// Without it, arbitration is round-robin.
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

module pwm_mux_arbiter #(
  parameter int DATA_W = `PWMCOUNT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        req_i,
  output logic [7:0]        ack_o,
  output logic [2:0]        sel_o,
  input  logic [DATA_W-1:0] mux_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [2:0]        m_id_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, LOAD, XFER} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] eff_req;
  logic [2:0] winner;
  logic       handshake;

  // A channel whose ack is visible this cycle must not win again immediately.
  assign eff_req   = req_i & ~ack_o;
  assign handshake = (state == XFER) && m_ready_i;
  assign busy_o    = (state != IDLE);

`ifdef PWMMUX_FIXED_PRIO_EN
  // Lowest-index set bit wins.
  function automatic logic [2:0] pick(input logic [7:0] r);
    logic [2:0] w;
    w = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r[i]) w = 3'(i);
    end
    return w;
  endfunction

  // Winner selection from the masked request vector.
  always_comb begin
    winner = pick(eff_req);
  end
`else
  logic [2:0] last_grant;

  // First set bit scanning upward from last+1, wrapping 7 to 0.
  function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] last);
    logic [2:0] w;
    logic [2:0] idx;
    logic       found;
    w     = 3'd0;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = last + 3'(i);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  // Winner selection from the masked request vector.
  always_comb begin
    winner = pick(eff_req, last_grant);
  end

  // Remember the last channel that completed a handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 3'd7;
    end else if (handshake) begin
      last_grant <= m_id_o;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|eff_req) state_nxt = LOAD;
      LOAD:    state_nxt = XFER;
      XFER:    if (m_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Select, capture and handshake registers; ack is a one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_o     <= 3'd0;
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_id_o    <= 3'd0;
      ack_o     <= 8'd0;
    end else begin
      ack_o <= 8'd0;
      case (state)
        IDLE: begin
          if (|eff_req) sel_o <= winner;
        end
        LOAD: begin
          // The mux has had a full cycle to settle on sel_o.
          m_data_o  <= mux_data_i;
          m_id_o    <= sel_o;
          m_valid_o <= 1'b1;
        end
        XFER: begin
          if (m_ready_i) begin
            m_valid_o <= 1'b0;
            ack_o     <= 8'(1) << m_id_o;
          end
        end
        default: begin
          m_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_mux_arbiter.sv
// Directed testbench for pwm_mux_arbiter: a vector table plus hand-written
// multi-cycle sequences for fairness, back-pressure, wrap, and async reset.
module tb_pwm_mux_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  req;
  logic [7:0]  ack;
  logic [2:0]  sel;
  logic [15:0] mux_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [2:0]  m_id;
  logic        busy;

  logic [15:0] mux_tab [8];
  int          checks = 0;
  int          errors = 0;

  assign mux_data = mux_tab[sel];

  always #5 clk = ~clk;

  pwm_mux_arbiter #(.DATA_W(16)) dut (
    .clk(clk), .rst(rst), .req_i(req), .ack_o(ack), .sel_o(sel),
    .mux_data_i(mux_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_data_o(m_data), .m_id_o(m_id), .busy_o(busy)
  );

  typedef struct {
    logic [7:0]  req;
    logic        rdy;
    logic [2:0]  sel;
    logic        vld;
    logic [15:0] data;
    logic [2:0]  id;
    logic [7:0]  ack;
    logic        busy;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [2:0] e_sel, input logic e_vld,
                         input logic [15:0] e_data, input logic [2:0] e_id,
                         input logic [7:0] e_ack, input logic e_busy);
    check({nm, ".sel"},   32'(sel),     32'(e_sel));
    check({nm, ".valid"}, 32'(m_valid), 32'(e_vld));
    check({nm, ".data"},  32'(m_data),  32'(e_data));
    check({nm, ".id"},    32'(m_id),    32'(e_id));
    check({nm, ".ack"},   32'(ack),     32'(e_ack));
    check({nm, ".busy"},  32'(busy),    32'(e_busy));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    step();
    rst = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) mux_tab[i] = 16'h1231 + 16'(i);
    vecs[0] = '{8'h08, 1'b1, 3'd3, 1'b0, 16'h0000, 3'd0, 8'h00, 1'b1};
    vecs[1] = '{8'h08, 1'b1, 3'd3, 1'b1, 16'h1234, 3'd3, 8'h00, 1'b1};
    vecs[2] = '{8'h08, 1'b1, 3'd3, 1'b0, 16'h1234, 3'd3, 8'h08, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 3'd3, 1'b0, 16'h1234, 3'd3, 8'h00, 1'b0};

    req = 8'h00;
    m_ready = 1'b1;
    rst = 1'b1;
    #12;
    chk_all("reset", 3'd0, 1'b0, 16'h0, 3'd0, 8'h00, 1'b0);
    step();
    rst = 1'b0;

    // Single request, table driven.
    for (int v = 0; v < 4; v++) begin
      req = vecs[v].req;
      m_ready = vecs[v].rdy;
      step();
      chk_all($sformatf("vec%0d", v), vecs[v].sel, vecs[v].vld, vecs[v].data,
              vecs[v].id, vecs[v].ack, vecs[v].busy);
    end

    // Round-robin fairness from reset with all eight requesting.
    do_reset();
    req = 8'hFF;
    m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("rr%0d.sel", k), 32'(sel), k);
      step();
      check($sformatf("rr%0d.valid", k), 32'(m_valid), 1);
      check($sformatf("rr%0d.id", k), 32'(m_id), k);
      check($sformatf("rr%0d.data", k), 32'(m_data), 32'(16'h1231 + 16'(k)));
      step();
      check($sformatf("rr%0d.ack", k), 32'(ack), 32'(8'(1) << k));
      req[k] = 1'b0;
    end
    step();
    check("rr_done.busy", 32'(busy), 0);

    // Back-pressure: stall ten cycles while the mux input moves.
    req = 8'h20;
    m_ready = 1'b0;
    step();
    step();
    chk_all("bp_start", 3'd5, 1'b1, 16'h1236, 3'd5, 8'h00, 1'b1);
    for (int c = 0; c < 10; c++) begin
      mux_tab[5] = 16'hA000 + 16'(c);
      step();
      chk_all($sformatf("bp_stall%0d", c), 3'd5, 1'b1, 16'h1236, 3'd5, 8'h00, 1'b1);
    end
    m_ready = 1'b1;
    step();
    chk_all("bp_release", 3'd5, 1'b0, 16'h1236, 3'd5, 8'h20, 1'b0);
    req = 8'h00;
    mux_tab[5] = 16'h1236;
    step();
    check("bp_single_ack", 32'(ack), 0);

`ifndef PWMMUX_FIXED_PRIO_EN
    // Wrap: serve channel 6, then 8'h81 must give 7 then 0, never 7 twice.
    req = 8'h40;
    step(); step(); step();
    check("wrap_pre.ack", 32'(ack), 32'h40);
    req = 8'h81;
    step();
    check("wrap7.sel", 32'(sel), 7);
    step();
    check("wrap7.id", 32'(m_id), 7);
    step();
    check("wrap7.ack", 32'(ack), 32'h80);
    step();
    check("wrap0.sel", 32'(sel), 0);
    req = 8'h01;
    step();
    check("wrap0.id", 32'(m_id), 0);
    step();
    check("wrap0.ack", 32'(ack), 32'h01);
    req = 8'h00;
    step();
    check("wrap_idle.busy", 32'(busy), 0);
    check("wrap_idle.sel", 32'(sel), 0);
`else
    // Fixed priority: channel 1 always beats channel 7 from a fresh IDLE.
    for (int r = 0; r < 3; r++) begin
      req = 8'h82;
      step();
      check($sformatf("prio%0d.sel", r), 32'(sel), 1);
      step();
      check($sformatf("prio%0d.id", r), 32'(m_id), 1);
      step();
      check($sformatf("prio%0d.ack", r), 32'(ack), 32'h02);
      req = 8'h00;
      step();
    end
`endif

    // Asynchronous reset while a transfer waits in XFER.
    req = 8'h10;
    m_ready = 1'b0;
    step();
    step();
    check("ar_pre.valid", 32'(m_valid), 1);
    rst = 1'b1;
    #1;
    chk_all("ar_async", 3'd0, 1'b0, 16'h0, 3'd0, 8'h00, 1'b0);
    step();
    check("ar_held.ack", 32'(ack), 0);
    rst = 1'b0;
    req = 8'h81;
    m_ready = 1'b1;
    step();
    check("ar_next.sel", 32'(sel), 0);
    step();
    check("ar_next.id", 32'(m_id), 0);
    step();
    check("ar_next.ack", 32'(ack), 32'h01);
    req = 8'h00;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
